// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants for the receive buffer, the transmitter and the MMIO decode.
// Status-bit positions give where the RX buffer flags sit in the STATUS register.
package uart_rx_fifo_pkg;

   localparam int UART_DATA_W        = 8;
   localparam int UART_RX_FIFO_DEPTH = 16;

   localparam int STATUS_RX_FULL_BIT     = 3;
   localparam int STATUS_RX_OVERFLOW_BIT = 4;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte-in / byte-out signal bundle between uart_rx, the RX buffer and the MMIO read path.
// The slave modport is the buffer; master is whoever drives bytes, reads and control pulses.
interface uart_rx_fifo_if
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_RX_FIFO_DEPTH
) ();

   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] i_rx_data;
   logic              i_rx_valid;
   logic              o_rx_ack;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              i_read_ack;
   logic [CW-1:0]     o_count;
   logic              o_full;
   logic              o_overflow;
   logic              i_clr_overflow;
   logic              i_flush;

   modport master (
      output i_rx_data, i_rx_valid, i_read_ack, i_clr_overflow, i_flush,
      input  o_rx_ack, o_data, o_valid, o_count, o_full, o_overflow
   );

   modport slave (
      input  i_rx_data, i_rx_valid, i_read_ack, i_clr_overflow, i_flush,
      output o_rx_ack, o_data, o_valid, o_count, o_full, o_overflow
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer: always acks uart_rx, drops and flags bytes
// that arrive while full, and presents the head byte to the RX_DATA read path.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DATA_W = UART_DATA_W,
   parameter int DEPTH  = UART_RX_FIFO_DEPTH
) (
   input logic           i_clk,
   input logic           i_rst,
   uart_rx_fifo_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic              valid;
   logic              full;
   logic              overflow;
   logic              push;
   logic              pop;
   logic              drop;

   // A pop frees the slot a simultaneous push needs, so a full FIFO can still accept.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      count_next = count;
      pop        = bus.i_read_ack && valid;
      push       = bus.i_rx_valid && (!full || pop);
      drop       = bus.i_rx_valid && full && !pop && !bus.i_flush;
      unique case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         valid    <= 1'b0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            valid <= (count_next != '0);
            full  <= (count_next == CW'(DEPTH));
         end
         if (drop)                    overflow <= 1'b1;
         else if (bus.i_clr_overflow) overflow <= 1'b0;
      end
   end

   // NOTE: storage has no reset; o_valid gates every read, so stale contents are never visible.
   always_ff @(posedge i_clk) begin
      if (push && !bus.i_flush) mem[wr_ptr] <= bus.i_rx_data;
   end

   assign bus.o_rx_ack   = bus.i_rx_valid;
   assign bus.o_data     = valid ? mem[rd_ptr] : '0;
   assign bus.o_valid    = valid;
   assign bus.o_count    = count;
   assign bus.o_full     = full;
   assign bus.o_overflow = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based reference model scores every cycle while
// directed and randomized traffic drives pushes, reads, flushes and resets.
module tb_uart_rx_fifo;
   import uart_rx_fifo_pkg::*;

   localparam int DEPTH = UART_RX_FIFO_DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_fifo_if #(.DATA_W(UART_DATA_W), .DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DATA_W(UART_DATA_W), .DEPTH(DEPTH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int         n_compared   = 0;
   int         n_mismatched = 0;
   logic [7:0] exp_q[$];
   logic       m_ovf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO is a bounded queue; a byte arriving at a full queue is lost.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_ovf = 1'b0;
      end else if (bus.i_flush) begin
         exp_q.delete();
         if (bus.i_clr_overflow) m_ovf = 1'b0;
      end else begin
         if (bus.i_rx_valid && exp_q.size() >= DEPTH) m_ovf = 1'b1;
         else begin
            if (bus.i_rx_valid) exp_q.push_back(bus.i_rx_data);
            if (bus.i_clr_overflow) m_ovf = 1'b0;
         end
      end
   end

   // Monitor: compares visible state mid-cycle and retires the head byte on a read.
   always @(negedge clk) begin
      int sz;
      sz = exp_q.size();
      check("count",    32'(bus.o_count), 32'(sz));
      check("valid",    32'(bus.o_valid), 32'(sz > 0));
      check("full",     32'(bus.o_full), 32'(sz == DEPTH));
      check("overflow", 32'(bus.o_overflow), 32'(m_ovf));
      check("rx_ack",   32'(bus.o_rx_ack), 32'(bus.i_rx_valid));
      check("data",     32'(bus.o_data), (sz > 0) ? 32'(exp_q[0]) : 32'd0);
      if (!rst && !bus.i_flush && bus.i_read_ack && sz > 0) void'(exp_q.pop_front());
      else if (!rst && bus.i_flush && bus.i_read_ack && sz > 0) void'(exp_q.pop_front());
   end

   task automatic step(input logic v, input logic [7:0] d, input logic ra,
                       input logic clr = 1'b0, input logic fl = 1'b0);
      bus.i_rx_valid     = v;
      bus.i_rx_data      = d;
      bus.i_read_ack     = ra;
      bus.i_clr_overflow = clr;
      bus.i_flush        = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      logic [7:0] b;
      logic       ovf_before;
      bus.i_rx_valid = 1'b0; bus.i_rx_data = '0; bus.i_read_ack = 1'b0;
      bus.i_clr_overflow = 1'b0; bus.i_flush = 1'b0;
      #2;
      check("reset_valid", 32'(bus.o_valid), 32'd0);
      check("reset_count", 32'(bus.o_count), 32'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Single byte: visible the cycle after the push, gone after one read.
      step(1'b1, 8'hA5, 1'b0);
      check("t1_valid", 32'(bus.o_valid), 32'd1);
      check("t1_data",  32'(bus.o_data), 32'hA5);
      check("t1_count", 32'(bus.o_count), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      check("t1_count_after_read", 32'(bus.o_count), 32'd0);
      check("t1_data_after_read",  32'(bus.o_data), 32'd0);

      // Fill to full, drop one byte, drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
      check("t2_full",  32'(bus.o_full), 32'd1);
      check("t2_count", 32'(bus.o_count), 32'(DEPTH));
      step(1'b1, 8'h55, 1'b0);
      check("t2_overflow", 32'(bus.o_overflow), 32'd1);
      check("t2_count_after_drop", 32'(bus.o_count), 32'(DEPTH));
      drain();
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check("t2_overflow_cleared", 32'(bus.o_overflow), 32'd0);

      // Full with coincident push and read: no drop, 0x77 lands last.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'h77, 1'b1);
      check("t3_count",    32'(bus.o_count), 32'(DEPTH));
      check("t3_overflow", 32'(bus.o_overflow), 32'd0);
      drain();

      // Interleaved push/read pairs at varying occupancy, wrapping the pointers.
      for (int i = 0; i < 40; i++) begin
         b = 8'($urandom_range(0, 255));
         step(1'b1, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) step(1'b0, 8'h00, 1'b1);
      end
      drain();

      // Randomized traffic with varying push/read bias and rare clear/flush pulses.
      for (int i = 0; i < 1600; i++) begin
         int bias;
         bias = (i / 200) % 4;
         step(1'($urandom_range(0, 3) < 3 - (bias % 3)),
              8'($urandom_range(0, 255)),
              1'($urandom_range(0, 3) < 1 + bias),
              1'($urandom_range(0, 31) == 0),
              1'($urandom_range(0, 127) == 0));
      end
      drain();

      // Read on empty is ignored; flush with a coincident push empties the FIFO.
      step(1'b0, 8'h00, 1'b1);
      check("t5_empty_count", 32'(bus.o_count), 32'd0);
      check("t5_empty_valid", 32'(bus.o_valid), 32'd0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      ovf_before = bus.o_overflow;
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      check("t5_flush_count", 32'(bus.o_count), 32'd0);
      check("t5_flush_valid", 32'(bus.o_valid), 32'd0);
      check("t5_flush_ovf",   32'(bus.o_overflow), 32'(ovf_before));

      // Drop coinciding with clear: set wins.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
      step(1'b1, 8'h99, 1'b0, 1'b1);
      check("t6_set_wins", 32'(bus.o_overflow), 32'd1);

      // Asynchronous reset between edges clears the outputs at once.
      bus.i_rx_valid = 1'b1;
      #3 rst = 1'b1;
      #1;
      check("t6_rst_valid",    32'(bus.o_valid), 32'd0);
      check("t6_rst_count",    32'(bus.o_count), 32'd0);
      check("t6_rst_full",     32'(bus.o_full), 32'd0);
      check("t6_rst_overflow", 32'(bus.o_overflow), 32'd0);
      check("t6_rst_data",     32'(bus.o_data), 32'd0);
      check("t6_rst_ack",      32'(bus.o_rx_ack), 32'd1);
      @(posedge clk); #1; rst = 1'b0;
      step(1'b1, 8'h3C, 1'b0);
      check("t6_after_rst_data", 32'(bus.o_data), 32'h3C);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
